// File: rtl/parking_pkg.sv
// Shared encodings for the parking occupancy controller: FSM states,
// adder operation select, gate sides and the count width.
package parking_pkg;

    localparam int COUNT_W = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam logic SIDE_ENTRY = 1'b0;
    localparam logic SIDE_EXIT  = 1'b1;

    // Entry adds a vehicle, exit removes one.
    function automatic logic side_to_op(input logic side);
        return (side == SIDE_ENTRY) ? OP_ADD : OP_SUB;
    endfunction

    // Add must not carry out; subtract must carry out (no borrow).
    function automatic logic carry_ok(input logic op, input logic cout);
        return (op == OP_ADD) ? ~cout : cout;
    endfunction

endpackage

// File: rtl/adder_subtractor_8bit.sv
// 8-bit adder/subtractor: S=0 gives A+B, S=1 gives A-B as A+~B+1.
// Cout is the raw carry out, so for subtract Cout=1 means no borrow.
module adder_subtractor_8bit (
    input  logic       S,
    input  logic [7:0] A,
    input  logic [7:0] B,
    output logic [7:0] Sum,
    output logic       Cout
);

    logic [8:0] total_s;

    assign total_s = {1'b0, A} + {1'b0, B ^ {8{S}}} + {8'd0, S};
    assign Sum     = total_s[7:0];
    assign Cout    = total_s[8];

endmodule

// File: rtl/parking_count_controller.sv
// Lot occupancy controller: arbitrates entry/exit requests onto one shared
// adder/subtractor, enforces full/empty limits and pulses grant or deny.
module parking_count_controller
    import parking_pkg::*;
#(
    parameter int CAPACITY = 200,
    parameter bit FAIR     = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               entry_req,
    input  logic               exit_req,
    output logic               entry_gnt,
    output logic               entry_deny,
    output logic               exit_gnt,
    output logic               exit_deny,
    output logic [COUNT_W-1:0] count,
    output logic               full,
    output logic               empty,
    output logic               busy,
    output logic               err
);

    localparam logic [COUNT_W-1:0] CAP_C = CAPACITY[COUNT_W-1:0];

    logic [1:0]         state_q, state_d;
    logic               side_q, side_d;
    logic               last_q, last_d;
    logic               limit_q, limit_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [COUNT_W-1:0] sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               entry_gnt_q, entry_gnt_d;
    logic               entry_deny_q, entry_deny_d;
    logic               exit_gnt_q, exit_gnt_d;
    logic               exit_deny_q, exit_deny_d;
    logic               full_q, full_d;
    logic               empty_q, empty_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;

    logic [COUNT_W-1:0] sum_s;
    logic               cout_s;
    logic               op_s;

    assign op_s = side_to_op(side_q);

    adder_subtractor_8bit u_addsub (
        .S    (op_s),
        .A    (count_q),
        .B    (8'd1),
        .Sum  (sum_s),
        .Cout (cout_s)
    );

    // Next-state and output decode for the IDLE -> CALC -> DONE sequence
    always_comb begin
        state_d      = state_q;
        side_d       = side_q;
        last_d       = last_q;
        limit_d      = limit_q;
        count_d      = count_q;
        sum_d        = sum_q;
        cout_d       = cout_q;
        err_d        = err_q;
        entry_gnt_d  = 1'b0;
        entry_deny_d = 1'b0;
        exit_gnt_d   = 1'b0;
        exit_deny_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (entry_req && exit_req) begin
                    side_d  = FAIR ? ~last_q : SIDE_ENTRY;
                    state_d = ST_CALC;
                end else if (entry_req) begin
                    side_d  = SIDE_ENTRY;
                    state_d = ST_CALC;
                end else if (exit_req) begin
                    side_d  = SIDE_EXIT;
                    state_d = ST_CALC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                sum_d   = sum_s;
                cout_d  = cout_s;
                limit_d = (side_q == SIDE_ENTRY) ? (count_q == CAP_C)
                                                 : (count_q == 8'd0);
                state_d = ST_DONE;
            end
            ST_DONE: begin
                last_d  = side_q;
                state_d = ST_IDLE;
                // A carry violation is refused like a limit hit so the gate is released.
                if (limit_q || !carry_ok(op_s, cout_q)) begin
                    if (!limit_q) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = err_q;
                    end
                    entry_deny_d = (side_q == SIDE_ENTRY);
                    exit_deny_d  = (side_q == SIDE_EXIT);
                end else begin
                    count_d     = sum_q;
                    entry_gnt_d = (side_q == SIDE_ENTRY);
                    exit_gnt_d  = (side_q == SIDE_EXIT);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        full_d  = (count_d == CAP_C);
        empty_d = (count_d == 8'd0);
        busy_d  = (state_d != ST_IDLE);
    end

    // State, count and registered output flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            side_q       <= SIDE_ENTRY;
            last_q       <= SIDE_EXIT;
            limit_q      <= 1'b0;
            count_q      <= 8'd0;
            sum_q        <= 8'd0;
            cout_q       <= 1'b0;
            entry_gnt_q  <= 1'b0;
            entry_deny_q <= 1'b0;
            exit_gnt_q   <= 1'b0;
            exit_deny_q  <= 1'b0;
            full_q       <= 1'b0;
            empty_q      <= 1'b1;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            side_q       <= side_d;
            last_q       <= last_d;
            limit_q      <= limit_d;
            count_q      <= count_d;
            sum_q        <= sum_d;
            cout_q       <= cout_d;
            entry_gnt_q  <= entry_gnt_d;
            entry_deny_q <= entry_deny_d;
            exit_gnt_q   <= exit_gnt_d;
            exit_deny_q  <= exit_deny_d;
            full_q       <= full_d;
            empty_q      <= empty_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
        end
    end

    assign entry_gnt  = entry_gnt_q;
    assign entry_deny = entry_deny_q;
    assign exit_gnt   = exit_gnt_q;
    assign exit_deny  = exit_deny_q;
    assign count      = count_q;
    assign full       = full_q;
    assign empty      = empty_q;
    assign busy       = busy_q;
    assign err        = err_q;

endmodule

// File: tb/tb_parking_count_controller.sv
// Directed bench for parking_count_controller: three instances cover the
// default lot, a 3-space fair lot and a 3-space entry-priority lot.
module tb_parking_count_controller;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic a_entry = 1'b0, a_exit = 1'b0;
    logic a_eg, a_ed, a_xg, a_xd, a_full, a_empty, a_busy, a_err;
    logic [7:0] a_count;

    logic b_entry = 1'b0, b_exit = 1'b0;
    logic b_eg, b_ed, b_xg, b_xd, b_full, b_empty, b_busy, b_err;
    logic [7:0] b_count;

    logic c_entry = 1'b0, c_exit = 1'b0;
    logic c_eg, c_ed, c_xg, c_xd, c_full, c_empty, c_busy, c_err;
    logic [7:0] c_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    parking_count_controller #(.CAPACITY(200), .FAIR(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .entry_req(a_entry), .exit_req(a_exit),
        .entry_gnt(a_eg), .entry_deny(a_ed), .exit_gnt(a_xg), .exit_deny(a_xd),
        .count(a_count), .full(a_full), .empty(a_empty), .busy(a_busy), .err(a_err)
    );

    parking_count_controller #(.CAPACITY(3), .FAIR(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .entry_req(b_entry), .exit_req(b_exit),
        .entry_gnt(b_eg), .entry_deny(b_ed), .exit_gnt(b_xg), .exit_deny(b_xd),
        .count(b_count), .full(b_full), .empty(b_empty), .busy(b_busy), .err(b_err)
    );

    parking_count_controller #(.CAPACITY(3), .FAIR(1'b0)) dut_c (
        .clk(clk), .rst_n(rst_n), .entry_req(c_entry), .exit_req(c_exit),
        .entry_gnt(c_eg), .entry_deny(c_ed), .exit_gnt(c_xg), .exit_deny(c_xd),
        .count(c_count), .full(c_full), .empty(c_empty), .busy(c_busy), .err(c_err)
    );

    function automatic logic any_pulse(input int which);
        case (which)
            0:       return a_eg | a_ed | a_xg | a_xd;
            1:       return b_eg | b_ed | b_xg | b_xd;
            default: return c_eg | c_ed | c_xg | c_xd;
        endcase
    endfunction

    // Counts falling edges until the instance pulses a grant/deny (bounded).
    task automatic wait_pulse(input int which, output int cyc);
        cyc = 0;
        while (!any_pulse(which) && cyc < 12) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic a_enter();
        int cyc;
        a_entry = 1'b1;
        wait_pulse(0, cyc);
        a_entry = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({a_eg, a_ed, a_xg, a_xd} !== 4'b0000) begin
            errors++; $display("FAIL reset_pulses got=%b want=0000", {a_eg, a_ed, a_xg, a_xd});
        end
        checks++;
        if (a_count !== 8'd0 || b_count !== 8'd0 || c_count !== 8'd0) begin
            errors++; $display("FAIL reset_count got=%0d/%0d/%0d want=0", a_count, b_count, c_count);
        end
        checks++;
        if ({a_empty, a_full, a_busy, a_err} !== 4'b1000) begin
            errors++; $display("FAIL reset_flags got=%b want=1000", {a_empty, a_full, a_busy, a_err});
        end
    endtask

    task automatic test_exit_empty();
        int cyc;
        a_exit = 1'b1;
        wait_pulse(0, cyc);
        a_exit = 1'b0;
        checks++;
        if (cyc !== 3) begin
            errors++; $display("FAIL exit_empty_latency got=%0d want=3", cyc);
        end
        checks++;
        if ({a_xd, a_xg, a_eg, a_ed} !== 4'b1000) begin
            errors++; $display("FAIL exit_empty_pulse got=%b want=1000", {a_xd, a_xg, a_eg, a_ed});
        end
        checks++;
        if (a_count !== 8'd0 || a_err !== 1'b0 || a_empty !== 1'b1) begin
            errors++; $display("FAIL exit_empty_state got=cnt%0d err%b empty%b want=cnt0 err0 empty1",
                               a_count, a_err, a_empty);
        end
        @(negedge clk);
        checks++;
        if (a_xd !== 1'b0) begin
            errors++; $display("FAIL exit_deny_width got=%b want=0", a_xd);
        end
    endtask

    task automatic test_single_entry();
        int cyc;
        a_entry = 1'b1;
        @(negedge clk);
        checks++;
        if (a_busy !== 1'b1) begin
            errors++; $display("FAIL entry_busy got=%b want=1", a_busy);
        end
        wait_pulse(0, cyc);
        a_entry = 1'b0;
        checks++;
        if (cyc !== 2 || a_eg !== 1'b1) begin
            errors++; $display("FAIL entry_gnt got=cyc%0d gnt%b want=cyc2 gnt1", cyc, a_eg);
        end
        checks++;
        if (a_count !== 8'd1 || a_empty !== 1'b0 || a_busy !== 1'b0) begin
            errors++; $display("FAIL entry_state got=cnt%0d empty%b busy%b want=cnt1 empty0 busy0",
                               a_count, a_empty, a_busy);
        end
        @(negedge clk);
        checks++;
        if (a_eg !== 1'b0) begin
            errors++; $display("FAIL entry_gnt_width got=%b want=0", a_eg);
        end
    endtask

    task automatic test_fair_alternate();
        int cyc;
        repeat (5) a_enter();
        a_exit = 1'b1;
        wait_pulse(0, cyc);
        a_exit = 1'b0;
        @(negedge clk);
        checks++;
        if (a_count !== 8'd5) begin
            errors++; $display("FAIL fair_setup_count got=%0d want=5", a_count);
        end
        for (int round = 0; round < 2; round++) begin
            a_entry = 1'b1;
            a_exit  = 1'b1;
            wait_pulse(0, cyc);
            a_entry = 1'b0;
            checks++;
            if (a_eg !== 1'b1 || a_xg !== 1'b0 || a_count !== 8'd6) begin
                errors++; $display("FAIL fair_first r%0d got=eg%b xg%b cnt%0d want=eg1 xg0 cnt6",
                                   round, a_eg, a_xg, a_count);
            end
            @(negedge clk);
            wait_pulse(0, cyc);
            a_exit = 1'b0;
            checks++;
            if (a_xg !== 1'b1 || a_eg !== 1'b0 || a_count !== 8'd5) begin
                errors++; $display("FAIL fair_second r%0d got=xg%b eg%b cnt%0d want=xg1 eg0 cnt5",
                                   round, a_xg, a_eg, a_count);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_calc();
        int pulses;
        a_entry = 1'b1;
        @(negedge clk);
        checks++;
        if (a_busy !== 1'b1) begin
            errors++; $display("FAIL midcalc_busy got=%b want=1", a_busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (a_count !== 8'd0 || a_busy !== 1'b0 || a_empty !== 1'b1) begin
            errors++; $display("FAIL midcalc_reset got=cnt%0d busy%b empty%b want=cnt0 busy0 empty1",
                               a_count, a_busy, a_empty);
        end
        a_entry = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (4) begin
            @(negedge clk);
            if (any_pulse(0)) pulses++;
        end
        checks++;
        if (pulses !== 0 || a_busy !== 1'b0) begin
            errors++; $display("FAIL midcalc_discard got=pulses%0d busy%b want=pulses0 busy0", pulses, a_busy);
        end
        a_enter();
        checks++;
        if (a_count !== 8'd1) begin
            errors++; $display("FAIL midcalc_resume got=%0d want=1", a_count);
        end
    endtask

    task automatic test_capacity();
        int cyc;
        for (int i = 0; i < 4; i++) begin
            b_entry = 1'b1;
            wait_pulse(1, cyc);
            b_entry = 1'b0;
            checks++;
            if ({b_eg, b_ed} !== ((i < 3) ? 2'b10 : 2'b01)) begin
                errors++; $display("FAIL cap_pulse i%0d got=%b want=%b", i, {b_eg, b_ed},
                                   (i < 3) ? 2'b10 : 2'b01);
            end
            checks++;
            if (b_count !== ((i < 3) ? i + 1 : 3) || b_full !== (i >= 2)) begin
                errors++; $display("FAIL cap_state i%0d got=cnt%0d full%b want=cnt%0d full%b",
                                   i, b_count, b_full, (i < 3) ? i + 1 : 3, (i >= 2));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_priority_full();
        int cyc;
        repeat (3) begin
            c_entry = 1'b1;
            wait_pulse(2, cyc);
            c_entry = 1'b0;
            @(negedge clk);
        end
        c_entry = 1'b1;
        c_exit  = 1'b1;
        wait_pulse(2, cyc);
        c_entry = 1'b0;
        checks++;
        if ({c_ed, c_eg, c_xg, c_xd} !== 4'b1000 || c_count !== 8'd3 || c_full !== 1'b1) begin
            errors++; $display("FAIL prio_first got=%b cnt%0d full%b want=1000 cnt3 full1",
                               {c_ed, c_eg, c_xg, c_xd}, c_count, c_full);
        end
        @(negedge clk);
        wait_pulse(2, cyc);
        c_exit = 1'b0;
        checks++;
        if ({c_xg, c_xd, c_eg, c_ed} !== 4'b1000 || c_count !== 8'd2 || c_full !== 1'b0) begin
            errors++; $display("FAIL prio_second got=%b cnt%0d full%b want=1000 cnt2 full0",
                               {c_xg, c_xd, c_eg, c_ed}, c_count, c_full);
        end
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_exit_empty();
        test_single_entry();
        test_fair_alternate();
        test_reset_mid_calc();
        test_capacity();
        test_priority_full();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
